adc_spi_reader_multi: RTL and testbench
=======================================

// Module: adc_spi_reader_multi
// PURPOSE
//  Parametrised multi-channel SPI ADC readout engine. Drives one shared CNV/SCLK pair to
//  N_CH ADCs in parallel, each with its own MISO line. Captures DATA_W bits per channel
//  MSB first. Presents all channels as one word on a valid/ready stream to the phase
//  processing path. Supports single-shot (start_i) and free-running (cont_i) modes, a
//  programmable SCLK divider and a programmable conversion wait.
// PARAMETERS
//  DATA_W   16  bits per sample, per channel (2..32)
//  N_CH     2   number of ADC channels sharing CNV/SCLK (1..8)
//  CLK_DIV  1   SCLK half-period in clk_i cycles (>=1)
//  T_CNV    4   clk_i cycles CNV is held high for conversion before readout (>=1)
// PORTS
//  clk_i          in   1             system clock
//  reset_ni       in   1             synchronous reset, active low
//  start_i        in   1             single-shot request; sampled only in IDLE
//  cont_i         in   1             1 = free-running conversions
//  spi_miso_i     in   N_CH          per-channel MISO; bit k belongs to channel k
//  spi_clk_o      out  1             shared SCLK
//  spi_mosi_o     out  1             constant 1
//  cnv_o          out  1             conversion start / active-low CS
//  data_o         out  N_CH*DATA_W   channel k in bits [k*DATA_W +: DATA_W], two's complement
//  valid_o        out  1             data_o holds an unconsumed sample set
//  ready_i        in   1             consumer accepts when valid_o & ready_i
//  overrun_o      out  1             sticky: an unconsumed sample set was overwritten
//  overrun_clr_i  in   1             clears overrun_o
//  is_idle_o      out  1             1 only in IDLE
// BEHAVIOUR
//  - Interface: one clock (clk_i). Reset is synchronous and active-low (reset_ni).
//  - Reset (reset_ni=0 at a clk_i edge) overrides everything, including mid-transfer:
//    state=IDLE, cnv_o=1, spi_clk_o=0, data_o=0, valid_o=0, overrun_o=0. The shift
//    registers and counters clear. A partially shifted sample is discarded.
//  - States:
//    IDLE  : cnv_o=1. Goes to CONV if start_i|cont_i.
//    CONV  : cnv_o=1 for exactly T_CNV cycles, then CSLOW.
//    CSLOW : cnv_o=0 for 1 cycle, then SHIFT.
//    SHIFT : cnv_o=0. DATA_W bit periods. Each period is CLK_DIV cycles with spi_clk_o=1,
//            then CLK_DIV cycles with spi_clk_o=0. On the last high cycle of each period
//            (falling edge), every spi_miso_i[k] is shifted into its channel register.
//            Bit counter runs DATA_W-1 down to 0. After bit 0 the state goes to DONE.
//    DONE  : cnv_o=1 for 1 cycle. All channel registers load into data_o and valid_o is set.
//            Next state is CONV if cont_i=1, otherwise IDLE.
//  - spi_clk_o is registered and glitch-free; it is 0 outside SHIFT.
//  - start_i is ignored outside IDLE. No wait for start_i to deassert.
//  - Latency from the edge that samples start_i in IDLE to valid_o=1 is
//    T_CNV+1+2*CLK_DIV*DATA_W+1 cycles (defaults: 38).
//  - Continuous period from one DONE to the next is T_CNV+1+2*CLK_DIV*DATA_W+1 cycles.
//    Clearing cont_i finishes the current conversion, then the block returns to IDLE.
//  - Output handshake: data_o is stable while valid_o=1 and ready_i=0. valid_o clears on
//    an accepting cycle unless DONE loads in the same cycle.
//  - DONE while valid_o=1 and ready_i=0: data_o is overwritten, valid_o stays 1,
//    overrun_o is set.
//  - DONE with valid_o&ready_i in the same cycle: the new data is loaded, valid_o stays 1,
//    no overrun.
//  - overrun_clr_i in the same cycle as a new overrun: set wins.
//  - Channel data is MSB first, no sign extension. The width is exactly DATA_W.
// TESTING
//  1. Reset defaults: hold reset_ni=0 for 3 cycles -> cnv_o=1, spi_clk_o=0, valid_o=0,
//     overrun_o=0, is_idle_o=1.
//  2. Single shot at defaults, MISO model ch0=0x8001, ch1=0x7FFE -> valid_o 38 cycles
//     after start, data_o=0x7FFE_8001, 16 SCLK pulses each 1 cycle high, then IDLE.
//  3. CLK_DIV=3, T_CNV=10, DATA_W=18, N_CH=1, sample 0x2ABCD -> CNV high 10 cycles,
//     SCLK 3 high/3 low, valid after 120 cycles, data_o=0x2ABCD.
//  4. cont_i=1, ready_i=0 throughout -> second DONE sets overrun_o=1 and data_o updates.
//     overrun_clr_i pulse -> overrun_o=0. With ready_i=1 throughout -> overrun_o stays 0.
//  5. Reset mid-SHIFT after 7 bits -> next cycle cnv_o=1, spi_clk_o=0, valid_o=0. A
//     following start gives a clean full sample.
//  6. start_i pulsed during SHIFT -> ignored: exactly one sample set, no second conversion.

Source files
------------

// File: rtl/adc_spi_reader_multi.sv
// adc_spi_reader_multi: multi-channel SPI ADC readout engine.
// One shared CNV/SCLK pair drives N_CH converters in parallel; each channel has its own
// MISO line and shift register. Finished sample sets are presented as one word on a
// valid/ready stream, with a sticky overrun flag for sets overwritten before acceptance.
`timescale 1ns/1ps
module adc_spi_reader_multi #(
  parameter int DATA_W  = 16,
  parameter int N_CH    = 2,
  parameter int CLK_DIV = 1,
  parameter int T_CNV   = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic                   cont_i,
  input  logic [N_CH-1:0]        spi_miso_i,
  output logic                   spi_clk_o,
  output logic                   spi_mosi_o,
  output logic                   cnv_o,
  output logic [N_CH*DATA_W-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overrun_o,
  input  logic                   overrun_clr_i,
  output logic                   is_idle_o
);

  localparam int CNV_W = (T_CNV > 1) ? $clog2(T_CNV) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNV_W-1:0] CNV_LAST = CNV_W'(T_CNV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    CSLOW,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNV_W-1:0] conv_cnt_q, conv_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             low_half_q, low_half_d;
  logic             sclk_q, sclk_d;
  logic             shift_en;
  logic             load_en;

  logic [N_CH-1:0][DATA_W-1:0] shreg_q;
  logic [N_CH*DATA_W-1:0]      data_q;
  logic                        valid_q;
  logic                        overrun_q;

  // Next-state, counter and SCLK decode. SCLK is produced as the next value of a
  // register so the pin never sees decode glitches; entering SHIFT starts a high half.
  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    low_half_d = low_half_q;
    sclk_d     = 1'b0;
    shift_en   = 1'b0;
    load_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i || cont_i) begin
          state_d    = CONV;
          conv_cnt_d = '0;
        end
      end
      CONV: begin
        if (conv_cnt_q == CNV_LAST) begin
          state_d = CSLOW;
        end else begin
          conv_cnt_d = conv_cnt_q + CNV_W'(1);
        end
      end
      CSLOW: begin
        state_d    = SHIFT;
        div_cnt_d  = '0;
        low_half_d = 1'b0;
        bit_cnt_d  = BIT_TOP;
        sclk_d     = 1'b1;
      end
      SHIFT: begin
        sclk_d = sclk_q;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!low_half_q) begin
            // last high cycle of the bit period: capture on the falling edge
            shift_en   = 1'b1;
            low_half_d = 1'b1;
            sclk_d     = 1'b0;
          end else begin
            low_half_d = 1'b0;
            if (bit_cnt_q == '0) begin
              state_d = DONE;
              sclk_d  = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q - BIT_W'(1);
              sclk_d    = 1'b1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        load_en = 1'b1;
        if (cont_i) begin
          state_d    = CONV;
          conv_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered SCLK.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      conv_cnt_q <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      low_half_q <= 1'b0;
      sclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      low_half_q <= low_half_d;
      sclk_q     <= sclk_d;
    end
  end

  // Per-channel MSB-first shift registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      shreg_q <= '0;
    end else if (shift_en) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        shreg_q[k] <= {shreg_q[k][DATA_W-2:0], spi_miso_i[k]};
      end
    end
  end

  // Output stream register: DONE load beats a same-cycle accept; overrun set beats clear.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load_en) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      if (load_en && valid_q && !ready_i) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign spi_clk_o  = sclk_q;
  assign spi_mosi_o = 1'b1;
  assign cnv_o      = !((state_q == CSLOW) || (state_q == SHIFT));
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overrun_o  = overrun_q;
  assign is_idle_o  = (state_q == IDLE);

endmodule

// File: tb/tb_adc_spi_reader_multi.sv
// Bench for adc_spi_reader_multi: a default instance checked every cycle against a
// conversion-position model, plus a second instance with a wide, slow configuration.
`timescale 1ns/1ps
module tb_adc_spi_reader_multi;

  localparam int DW  = 16;
  localparam int NC  = 2;
  localparam int CD  = 1;
  localparam int TC  = 4;
  localparam int P0  = TC + 1 + 2 * CD * DW + 1;
  localparam int DW1 = 18;
  localparam int CD1 = 3;
  localparam int TC1 = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start0 = 1'b0, cont0 = 1'b0, ready0 = 1'b0, clr0 = 1'b0;
  logic [NC-1:0] miso0 = '0;
  logic sclk0, mosi0, cnv0, valid0, ovr0, idle0;
  logic [NC*DW-1:0] data0;

  logic start1 = 1'b0;
  logic [0:0] miso1 = '0;
  logic sclk1, mosi1, cnv1, valid1, ovr1, idle1;
  logic [DW1-1:0] data1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adc_spi_reader_multi #(.DATA_W(DW), .N_CH(NC), .CLK_DIV(CD), .T_CNV(TC)) u0 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start0), .cont_i(cont0),
    .spi_miso_i(miso0), .spi_clk_o(sclk0), .spi_mosi_o(mosi0), .cnv_o(cnv0),
    .data_o(data0), .valid_o(valid0), .ready_i(ready0), .overrun_o(ovr0),
    .overrun_clr_i(clr0), .is_idle_o(idle0)
  );

  adc_spi_reader_multi #(.DATA_W(DW1), .N_CH(1), .CLK_DIV(CD1), .T_CNV(TC1)) u1 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start1), .cont_i(1'b0),
    .spi_miso_i(miso1), .spi_clk_o(sclk1), .spi_mosi_o(mosi1), .cnv_o(cnv1),
    .data_o(data1), .valid_o(valid1), .ready_i(1'b0), .overrun_o(ovr1),
    .overrun_clr_i(1'b0), .is_idle_o(idle1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ADC models: new word chosen when CNV falls, MSB first, next bit after each SCLK fall.
  logic [DW-1:0] w0 [NC];
  logic [DW-1:0] fix0 [NC];
  bit fixed0 = 1'b0;
  int falls0 = 0;
  logic pc0 = 1'b1, ps0 = 1'b0;
  always @(negedge clk) begin
    if (cnv0 === 1'b1) falls0 = 0;
    else if (pc0) begin
      for (int ch = 0; ch < NC; ch++) w0[ch] = fixed0 ? fix0[ch] : DW'($urandom);
    end else if (ps0 && !sclk0) falls0++;
    pc0 = cnv0;
    ps0 = sclk0;
    for (int ch = 0; ch < NC; ch++) miso0[ch] = (falls0 < DW) ? w0[ch][DW-1-falls0] : 1'b0;
  end

  logic [DW1-1:0] w1 = 18'h2ABCD;
  int falls1 = 0;
  logic ps1 = 1'b0;
  always @(negedge clk) begin
    if (cnv1 !== 1'b0) falls1 = 0;
    else if (ps1 && !sclk1) falls1++;
    ps1 = sclk1;
    miso1[0] = (falls1 < DW1) ? w1[DW1-1-falls1] : 1'b0;
  end

  // Reference model: position t within a conversion of P0 cycles.
  // t<TC: CNV high, t==TC: CS low, then 2*CD*DW SHIFT cycles, t==P0-1: DONE.
  bit m_known = 1'b0;
  bit m_busy = 1'b0;
  int m_t = 0;
  logic [NC*DW-1:0] m_cap = '0;
  logic [NC*DW-1:0] e_data = '0;
  logic e_valid = 1'b0, e_ovr = 1'b0, e_cnv = 1'b1, e_sclk = 1'b0, e_idle = 1'b1;

  always @(posedge clk) begin
    logic r, s, c, rd, cl;
    logic [NC-1:0] mi;
    int sidx, b;
    bit done;
    r = rst_n; s = start0; c = cont0; rd = ready0; cl = clr0; mi = miso0;
    if (!r) begin
      m_known = 1'b1; m_busy = 1'b0; m_t = 0; m_cap = '0;
      e_data = '0; e_valid = 1'b0; e_ovr = 1'b0;
    end else begin
      if (m_busy && m_t > TC && m_t < P0 - 1) begin
        sidx = m_t - TC - 1;
        if (sidx % (2 * CD) == CD - 1) begin
          b = DW - 1 - sidx / (2 * CD);
          for (int ch = 0; ch < NC; ch++) m_cap[ch*DW+b] = mi[ch];
        end
      end
      done = m_busy && (m_t == P0 - 1);
      if (done && e_valid && !rd) e_ovr = 1'b1;
      else if (cl) e_ovr = 1'b0;
      if (done) begin
        e_data = m_cap;
        e_valid = 1'b1;
      end else if (e_valid && rd) e_valid = 1'b0;
      if (!m_busy) begin
        if (s || c) begin m_busy = 1'b1; m_t = 0; end
      end else if (m_t == P0 - 1) begin
        if (c) m_t = 0; else m_busy = 1'b0;
      end else m_t++;
    end
    e_idle = !m_busy;
    e_cnv = !m_busy || (m_t < TC) || (m_t == P0 - 1);
    e_sclk = m_busy && (m_t > TC) && (m_t < P0 - 1) && (((m_t - TC - 1) % (2 * CD)) < CD);
    #1;
    if (m_known) begin
      chk("m_cnv", 64'(cnv0), 64'(e_cnv));
      chk("m_sclk", 64'(sclk0), 64'(e_sclk));
      chk("m_idle", 64'(idle0), 64'(e_idle));
      chk("m_valid", 64'(valid0), 64'(e_valid));
      chk("m_overrun", 64'(ovr0), 64'(e_ovr));
      chk("m_data", 64'(data0), 64'(e_data));
    end
  end

  // Observe one single-shot conversion; start must have been raised at the preceding negedge.
  task automatic measure(input int which, input int hl, output int lat, output int cnv_hi,
                         output int pulses, output int bad);
    logic c, sc, v, prev;
    int run;
    bit dropped;
    lat = -1; cnv_hi = 0; pulses = 0; bad = 0; run = 0; prev = 1'b0; dropped = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) begin start0 = 1'b0; start1 = 1'b0; end
      c = (which != 0) ? cnv1 : cnv0;
      sc = (which != 0) ? sclk1 : sclk0;
      v = (which != 0) ? valid1 : valid0;
      if (!dropped) begin
        if (c) cnv_hi++; else dropped = 1'b1;
      end
      if (sc == prev) run++;
      else begin
        if (prev && run != hl) bad++;
        if (!prev && pulses > 0 && run != hl) bad++;
        if (sc) pulses++;
        run = 1;
      end
      prev = sc;
      if (v) begin lat = k; break; end
    end
  endtask

  initial begin
    int lat, chi, pl, bad, cnt, rises;
    logic pv, pcv;

    // Reset defaults
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cnv", 64'(cnv0), 64'd1);
    chk("rst_sclk", 64'(sclk0), 64'd0);
    chk("rst_valid", 64'(valid0), 64'd0);
    chk("rst_overrun", 64'(ovr0), 64'd0);
    chk("rst_idle", 64'(idle0), 64'd1);
    chk("rst_mosi", 64'(mosi0), 64'd1);
    chk("rst_u1_state", 64'({cnv1, sclk1, valid1, ovr1, idle1, mosi1}), 64'b100011);
    rst_n = 1'b1;

    // Single shot at defaults with fixed words
    fixed0 = 1'b1; fix0[0] = 16'h8001; fix0[1] = 16'h7FFE;
    @(negedge clk); start0 = 1'b1;
    measure(0, CD, lat, chi, pl, bad);
    chk("t2_latency", 64'(lat), 64'd38);
    chk("t2_data", 64'(data0), 64'h7FFE8001);
    chk("t2_cnv_high", 64'(chi), 64'd4);
    chk("t2_pulses", 64'(pl), 64'd16);
    chk("t2_runs", 64'(bad), 64'd0);
    chk("t2_idle", 64'(idle0), 64'd1);
    ready0 = 1'b1; @(negedge clk); ready0 = 1'b0;
    chk("t2_consumed", 64'(valid0), 64'd0);

    // Wide/slow instance
    @(negedge clk); start1 = 1'b1;
    measure(1, CD1, lat, chi, pl, bad);
    chk("t3_latency", 64'(lat), 64'd120);
    chk("t3_data", 64'(data1), 64'h2ABCD);
    chk("t3_cnv_high", 64'(chi), 64'(TC1));
    chk("t3_pulses", 64'(pl), 64'd18);
    chk("t3_runs", 64'(bad), 64'd0);

    // Continuous mode without acceptance -> overrun
    fixed0 = 1'b0; cont0 = 1'b1; ready0 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (valid0) begin cnt = 1; break; end
    end
    chk("t4_first_valid", 64'(cnt), 64'd1);
    repeat (37) @(negedge clk);
    chk("t4_ovr_before", 64'(ovr0), 64'd0);
    @(negedge clk);
    chk("t4_ovr_set", 64'(ovr0), 64'd1);
    chk("t4_data_new", 64'(data0), 64'({w0[1], w0[0]}));
    cont0 = 1'b0; clr0 = 1'b1;
    @(negedge clk); clr0 = 1'b0;
    chk("t4_ovr_clr", 64'(ovr0), 64'd0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (idle0) begin cnt = 1; break; end
    end
    chk("t4_back_idle", 64'(cnt), 64'd1);
    ready0 = 1'b1; clr0 = 1'b1;
    @(negedge clk); clr0 = 1'b0; cont0 = 1'b1;
    cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (ovr0) cnt++;
    end
    chk("t4_no_ovr_ready", 64'(cnt), 64'd0);
    cont0 = 1'b0;
    repeat (45) @(negedge clk);
    ready0 = 1'b0;

    // Reset mid-shift after 7 bits
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (cnv0 === 1'b0 && falls0 == 7) begin cnt = 1; break; end
    end
    chk("t5_reached_7_bits", 64'(cnt), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_cnv", 64'(cnv0), 64'd1);
    chk("t5_rst_sclk", 64'(sclk0), 64'd0);
    chk("t5_rst_valid", 64'(valid0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk); start0 = 1'b1;
    measure(0, CD, lat, chi, pl, bad);
    chk("t5_latency", 64'(lat), 64'd38);
    chk("t5_data", 64'(data0), 64'({w0[1], w0[0]}));
    ready0 = 1'b1; @(negedge clk); ready0 = 1'b0;

    // start during SHIFT is ignored
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sclk0) begin cnt = 1; break; end
    end
    chk("t6_in_shift", 64'(cnt), 64'd1);
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    rises = 0; cnt = 0; pv = valid0; pcv = cnv0;
    repeat (120) begin
      @(negedge clk);
      if (valid0 && !pv) rises++;
      if (pcv && !cnv0) cnt++;
      pv = valid0; pcv = cnv0;
    end
    chk("t6_one_sample", 64'(rises), 64'd1);
    chk("t6_no_new_conv", 64'(cnt), 64'd0);
    chk("t6_idle", 64'(idle0), 64'd1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start0 = ($urandom_range(7) == 0);
      if ($urandom_range(40) == 0) cont0 = ~cont0;
      ready0 = 1'($urandom_range(1));
      clr0 = ($urandom_range(15) == 0);
      rst_n = ($urandom_range(600) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; start0 = 1'b0; cont0 = 1'b0; clr0 = 1'b0; ready0 = 1'b1;
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
